// File: rtl/sram_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_bridge_pkg
// Purpose  : Shared types and constants for the SRAM bridge: the controller
//            state encoding and the default read/write strobe lengths.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sram_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_WR      = 3'd2,
        ST_WR_HOLD = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int c_RD_WAIT_DEFAULT = 2;
    localparam int c_WR_WAIT_DEFAULT = 2;

endpackage
`default_nettype wire

// File: rtl/sram_wait_counter.sv
`default_nettype none
// ============================================================================
// Module   : sram_wait_counter
// Purpose  : Loadable down-counter that times the SRAM strobe phases.
//            Decrement saturates at zero so the count never wraps.
// Ports    : clock, reset_n    - clock, async active-low reset
//            load, load_value  - load a new count (has priority over dec)
//            dec               - decrement by one when non-zero
//            zero              - count is zero (last strobe cycle)
// Revision : 1.0 - initial release
// ============================================================================
module sram_wait_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : sram_bridge
// Purpose  : Bridges a simple read/write master with waitrequest onto an
//            asynchronous 16-bit SRAM. Each access: accept in IDLE, strobe
//            for RD_WAIT (read) or WR_WAIT + 1 hold (write) cycles, then one
//            DONE turnaround cycle where waitrequest drops.
// Ports    : clock, reset_n               - clock, async active-low reset
//            address/byteenable/read/write/writedata - master request
//            readdata/readdataready/waitrequest      - master response
//            sram_*                       - SRAM pad-side signals
//            rd_count/wr_count            - completed access counters
// Config   : SRAM_BRIDGE_STATS_EN - when defined, rd_count/wr_count are
//            saturating counters; otherwise both are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module sram_bridge
    import sram_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int BE_WIDTH   = DATA_WIDTH / 8,
    parameter int RD_WAIT    = c_RD_WAIT_DEFAULT,
    parameter int WR_WAIT    = c_WR_WAIT_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [BE_WIDTH-1:0]   byteenable,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] writedata,
    output logic [DATA_WIDTH-1:0] readdata,
    output logic                  readdataready,
    output logic                  waitrequest,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_dq_out,
    output logic                  sram_dq_oe,
    input  logic [DATA_WIDTH-1:0] sram_dq_in,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic                  sram_ub_n,
    output logic                  sram_lb_n,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count
);

    localparam int c_MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int c_CNT_W    = $clog2(c_MAX_WAIT + 1);
    // Load WAIT-1 so the zero flag marks the final strobe cycle.
    localparam logic [c_CNT_W-1:0] c_RD_LOAD = c_CNT_W'(RD_WAIT - 1);
    localparam logic [c_CNT_W-1:0] c_WR_LOAD = c_CNT_W'(WR_WAIT - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [BE_WIDTH-1:0]   r_be;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_rdy;
    logic                  w_accept;
    logic                  w_cnt_load;
    logic [c_CNT_W-1:0]    w_cnt_value;
    logic                  w_cnt_dec;
    logic                  w_cnt_zero;

    sram_wait_counter #(
        .WIDTH (c_CNT_W)
    ) u_wait_counter (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (w_cnt_load),
        .load_value (w_cnt_value),
        .dec        (w_cnt_dec),
        .zero       (w_cnt_zero)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_rdy   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_addr  <= address;
                r_be    <= byteenable;
                r_wdata <= writedata;
            end
            if ((r_state == ST_RD) && w_cnt_zero) begin
                r_rdata <= sram_dq_in;
            end
            // High exactly for the DONE cycle that follows a read.
            r_rdy <= (r_state == ST_RD) && w_cnt_zero;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_value  = '0;
        w_cnt_dec    = 1'b0;
        sram_ce_n    = 1'b1;
        sram_oe_n    = 1'b1;
        sram_we_n    = 1'b1;
        sram_ub_n    = 1'b1;
        sram_lb_n    = 1'b1;
        sram_dq_oe   = 1'b0;
        sram_dq_out  = '0;
        case (r_state)
            ST_IDLE: begin
                // Read has priority; a simultaneous write is dropped.
                if (read) begin
                    w_next_state = ST_RD;
                    w_accept     = 1'b1;
                    w_cnt_load   = 1'b1;
                    w_cnt_value  = c_RD_LOAD;
                end else if (write) begin
                    w_next_state = ST_WR;
                    w_accept     = 1'b1;
                    w_cnt_load   = 1'b1;
                    w_cnt_value  = c_WR_LOAD;
                end
            end
            ST_RD: begin
                w_cnt_dec = 1'b1;
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                sram_ub_n = ~r_be[1];
                sram_lb_n = ~r_be[0];
                if (w_cnt_zero) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_WR: begin
                w_cnt_dec   = 1'b1;
                sram_ce_n   = 1'b0;
                sram_we_n   = 1'b0;
                sram_ub_n   = ~r_be[1];
                sram_lb_n   = ~r_be[0];
                sram_dq_oe  = 1'b1;
                sram_dq_out = r_wdata;
                if (w_cnt_zero) begin
                    w_next_state = ST_WR_HOLD;
                end
            end
            ST_WR_HOLD: begin
                // we_n released while data and address stay stable.
                sram_ce_n    = 1'b0;
                sram_ub_n    = ~r_be[1];
                sram_lb_n    = ~r_be[0];
                sram_dq_oe   = 1'b1;
                sram_dq_out  = r_wdata;
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign sram_addr     = r_addr;
    assign readdata      = r_rdata;
    assign readdataready = r_rdy;
    assign waitrequest   = (read | write) && (r_state != ST_DONE);

`ifdef SRAM_BRIDGE_STATS_EN
    logic [31:0] r_rd_count;
    logic [31:0] r_wr_count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if (r_state == ST_DONE) begin
            // r_rdy distinguishes a read DONE from a write DONE.
            if (r_rdy) begin
                if (r_rd_count != '1) r_rd_count <= r_rd_count + 32'd1;
            end else begin
                if (r_wr_count != '1) r_wr_count <= r_wr_count + 32'd1;
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_bridge
// Purpose  : Directed self-checking bench for sram_bridge with a small
//            behavioural byte-lane SRAM model on the pad side.
// Ports    : none (top-level bench)
// Config   : SRAM_BRIDGE_STATS_EN selects the expected counter values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_bridge;

    logic        clock;
    logic        reset_n;
    logic [19:0] address;
    logic [1:0]  byteenable;
    logic        read;
    logic        write;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        readdataready;
    logic        waitrequest;
    logic [19:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    int n_tests = 0;
    int n_fail  = 0;

    sram_bridge dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .address       (address),
        .byteenable    (byteenable),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .readdata      (readdata),
        .readdataready (readdataready),
        .waitrequest   (waitrequest),
        .sram_addr     (sram_addr),
        .sram_dq_out   (sram_dq_out),
        .sram_dq_oe    (sram_dq_oe),
        .sram_dq_in    (sram_dq_in),
        .sram_ce_n     (sram_ce_n),
        .sram_oe_n     (sram_oe_n),
        .sram_we_n     (sram_we_n),
        .sram_ub_n     (sram_ub_n),
        .sram_lb_n     (sram_lb_n),
        .rd_count      (rd_count),
        .wr_count      (wr_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural SRAM: byte-lane writes while ce_n/we_n are low.
    logic [15:0] mem [0:255];
    always @(posedge clock) begin
        if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            if (!sram_ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq_out[15:8];
            if (!sram_lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq_out[7:0];
        end
    end
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 16'h0000;

    // Runs one request from IDLE and records per-cycle pad activity.
    // Cycle 0 is the acceptance cycle; traces hold one bit per cycle.
    task automatic bus_xfer(input logic rd, input logic wr, input logic [19:0] a,
                            input logic [1:0] be, input logic [15:0] wd,
                            output int lat, output int rdy_cyc, output int rdy_pulses,
                            output int we_low, output logic [15:0] rd_val,
                            output logic [15:0] dq_seen, output logic ub_seen,
                            output logic lb_seen, output logic [7:0] we_tr,
                            output logic [7:0] oe_tr, output logic [7:0] dqoe_tr);
        lat = -1; rdy_cyc = -1; rdy_pulses = 0; we_low = 0;
        rd_val = 16'h0; dq_seen = 16'h0; ub_seen = 1'b0; lb_seen = 1'b0;
        we_tr = '1; oe_tr = '1; dqoe_tr = '0;
        address = a; byteenable = be; writedata = wd; read = rd; write = wr;
        #1;
        for (int c = 0; c < 20; c++) begin
            if (c < 8) begin
                we_tr[c]   = sram_we_n;
                oe_tr[c]   = sram_oe_n;
                dqoe_tr[c] = sram_dq_oe;
            end
            if (!sram_we_n) begin we_low++; dq_seen = sram_dq_out; end
            if (!sram_ce_n) begin ub_seen = sram_ub_n; lb_seen = sram_lb_n; end
            if (readdataready) begin rdy_pulses++; rdy_cyc = c; rd_val = readdata; end
            if (!waitrequest) begin lat = c; break; end
            @(posedge clock); #1;
        end
        read = 1'b0; write = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            if (readdataready) rdy_pulses++;
            if (!sram_we_n) we_low++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; byteenable = '0; writedata = '0;
        repeat (3) @(posedge clock);
        #1;
        n_tests++; if (sram_ce_n !== 1'b1) begin n_fail++; $display("FAIL reset_ce_n got %b exp 1", sram_ce_n); end
        n_tests++; if (sram_oe_n !== 1'b1) begin n_fail++; $display("FAIL reset_oe_n got %b exp 1", sram_oe_n); end
        n_tests++; if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL reset_we_n got %b exp 1", sram_we_n); end
        n_tests++; if ({sram_ub_n, sram_lb_n} !== 2'b11) begin n_fail++; $display("FAIL reset_ub_lb got %b exp 11", {sram_ub_n, sram_lb_n}); end
        n_tests++; if (sram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL reset_dq_oe got %b exp 0", sram_dq_oe); end
        n_tests++; if (sram_addr !== 20'h0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", sram_addr); end
        n_tests++; if (sram_dq_out !== 16'h0) begin n_fail++; $display("FAIL reset_dq_out got %h exp 0", sram_dq_out); end
        n_tests++; if (readdata !== 16'h0) begin n_fail++; $display("FAIL reset_readdata got %h exp 0", readdata); end
        n_tests++; if (readdataready !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got %b exp 0", readdataready); end
        n_tests++; if (waitrequest !== 1'b0) begin n_fail++; $display("FAIL reset_waitreq got %b exp 0", waitrequest); end
        n_tests++; if ({rd_count, wr_count} !== 64'h0) begin n_fail++; $display("FAIL reset_counts got %0d/%0d exp 0/0", rd_count, wr_count); end
        reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_write();
        int lat, rc, rp, wl; logic [15:0] rv, dq; logic ub, lb; logic [7:0] wt, ot, dt;
        bus_xfer(1'b0, 1'b1, 20'h00010, 2'b11, 16'hBEEF, lat, rc, rp, wl, rv, dq, ub, lb, wt, ot, dt);
        n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL write_latency got %0d exp 4", lat); end
        n_tests++; if (wl !== 2) begin n_fail++; $display("FAIL write_we_low_cycles got %0d exp 2", wl); end
        n_tests++; if (wt[4:0] !== 5'b11001) begin n_fail++; $display("FAIL write_we_trace got %b exp 11001", wt[4:0]); end
        n_tests++; if (dt[4:0] !== 5'b01110) begin n_fail++; $display("FAIL write_dq_oe_trace got %b exp 01110", dt[4:0]); end
        n_tests++; if (dq !== 16'hBEEF) begin n_fail++; $display("FAIL write_dq_out got %h exp beef", dq); end
        n_tests++; if ({ub, lb} !== 2'b00) begin n_fail++; $display("FAIL write_ub_lb got %b exp 00", {ub, lb}); end
        n_tests++; if (rp !== 0) begin n_fail++; $display("FAIL write_no_rdy got %0d exp 0", rp); end
    endtask

    task automatic test_read();
        int lat, rc, rp, wl; logic [15:0] rv, dq; logic ub, lb; logic [7:0] wt, ot, dt;
        bus_xfer(1'b1, 1'b0, 20'h00010, 2'b11, 16'h0000, lat, rc, rp, wl, rv, dq, ub, lb, wt, ot, dt);
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL read_latency got %0d exp 3", lat); end
        n_tests++; if (rc !== 3) begin n_fail++; $display("FAIL read_rdy_cycle got %0d exp 3", rc); end
        n_tests++; if (rp !== 1) begin n_fail++; $display("FAIL read_rdy_pulses got %0d exp 1", rp); end
        n_tests++; if (rv !== 16'hBEEF) begin n_fail++; $display("FAIL read_data got %h exp beef", rv); end
        n_tests++; if (ot[3:0] !== 4'b1001) begin n_fail++; $display("FAIL read_oe_trace got %b exp 1001", ot[3:0]); end
        n_tests++; if (wt[3:0] !== 4'b1111) begin n_fail++; $display("FAIL read_we_trace got %b exp 1111", wt[3:0]); end
    endtask

    task automatic test_read_write_conflict();
        int lat, rc, rp, wl; logic [15:0] rv, dq; logic ub, lb; logic [7:0] wt, ot, dt;
        bus_xfer(1'b0, 1'b1, 20'h00020, 2'b11, 16'hA5A5, lat, rc, rp, wl, rv, dq, ub, lb, wt, ot, dt);
        bus_xfer(1'b1, 1'b1, 20'h00020, 2'b11, 16'h5555, lat, rc, rp, wl, rv, dq, ub, lb, wt, ot, dt);
        n_tests++; if (lat !== 3) begin n_fail++; $display("FAIL conflict_latency got %0d exp 3", lat); end
        n_tests++; if (wl !== 0) begin n_fail++; $display("FAIL conflict_we_low got %0d exp 0", wl); end
        n_tests++; if (rv !== 16'hA5A5) begin n_fail++; $display("FAIL conflict_data got %h exp a5a5", rv); end
        n_tests++; if (rp !== 1) begin n_fail++; $display("FAIL conflict_rdy_pulses got %0d exp 1", rp); end
    endtask

    task automatic test_byte_enable();
        int lat, rc, rp, wl; logic [15:0] rv, dq; logic ub, lb; logic [7:0] wt, ot, dt;
        bus_xfer(1'b0, 1'b1, 20'h00030, 2'b11, 16'hABCD, lat, rc, rp, wl, rv, dq, ub, lb, wt, ot, dt);
        bus_xfer(1'b0, 1'b1, 20'h00030, 2'b01, 16'h1234, lat, rc, rp, wl, rv, dq, ub, lb, wt, ot, dt);
        n_tests++; if ({ub, lb} !== 2'b10) begin n_fail++; $display("FAIL be01_ub_lb got %b exp 10", {ub, lb}); end
        bus_xfer(1'b1, 1'b0, 20'h00030, 2'b11, 16'h0000, lat, rc, rp, wl, rv, dq, ub, lb, wt, ot, dt);
        n_tests++; if (rv[7:0] !== 8'h34) begin n_fail++; $display("FAIL be01_low_byte got %h exp 34", rv[7:0]); end
        n_tests++; if (rv[15:8] !== 8'hAB) begin n_fail++; $display("FAIL be01_high_byte got %h exp ab", rv[15:8]); end
        // byteenable=0: full write cycle with both lanes masked.
        bus_xfer(1'b0, 1'b1, 20'h00030, 2'b00, 16'h9999, lat, rc, rp, wl, rv, dq, ub, lb, wt, ot, dt);
        n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL be00_latency got %0d exp 4", lat); end
        n_tests++; if ({ub, lb} !== 2'b11) begin n_fail++; $display("FAIL be00_ub_lb got %b exp 11", {ub, lb}); end
        n_tests++; if (wt[4:0] !== 5'b11001) begin n_fail++; $display("FAIL be00_we_trace got %b exp 11001", wt[4:0]); end
        bus_xfer(1'b1, 1'b0, 20'h00030, 2'b11, 16'h0000, lat, rc, rp, wl, rv, dq, ub, lb, wt, ot, dt);
        n_tests++; if (rv !== 16'hAB34) begin n_fail++; $display("FAIL be00_unchanged got %h exp ab34", rv); end
    endtask

    task automatic test_drop_request();
        int rdy_c; int pulses; logic [15:0] val;
        rdy_c = -1; pulses = 0; val = 16'h0;
        address = 20'h00010; byteenable = 2'b11; read = 1'b1;
        #1;
        @(posedge clock); #1;
        read = 1'b0;
        for (int c = 1; c < 8; c++) begin
            if (readdataready) begin pulses++; rdy_c = c; val = readdata; end
            @(posedge clock); #1;
        end
        n_tests++; if (rdy_c !== 3) begin n_fail++; $display("FAIL drop_rdy_cycle got %0d exp 3", rdy_c); end
        n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL drop_rdy_pulses got %0d exp 1", pulses); end
        n_tests++; if (val !== 16'hBEEF) begin n_fail++; $display("FAIL drop_data got %h exp beef", val); end
    endtask

    task automatic test_reset_mid_write();
        int pulses;
        pulses = 0;
        address = 20'h00040; byteenable = 2'b11; writedata = 16'hCAFE; write = 1'b1;
        #1;
        @(posedge clock); #1;
        n_tests++; if (sram_we_n !== 1'b0) begin n_fail++; $display("FAIL midrst_we_active got %b exp 0", sram_we_n); end
        reset_n = 1'b0;
        #1;
        n_tests++; if (sram_we_n !== 1'b1) begin n_fail++; $display("FAIL midrst_we_n got %b exp 1", sram_we_n); end
        n_tests++; if (sram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL midrst_dq_oe got %b exp 0", sram_dq_oe); end
        n_tests++; if (sram_ce_n !== 1'b1) begin n_fail++; $display("FAIL midrst_ce_n got %b exp 1", sram_ce_n); end
        write = 1'b0;
        @(posedge clock); #1;
        if (readdataready) pulses++;
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock); #1;
            if (readdataready) pulses++;
        end
        n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL midrst_no_rdy got %0d exp 0", pulses); end
    endtask

    task automatic test_stats();
        int lat, rc, rp, wl; logic [15:0] rv, dq; logic ub, lb; logic [7:0] wt, ot, dt;
        logic [31:0] exp_rd, exp_wr;
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        bus_xfer(1'b0, 1'b1, 20'h00050, 2'b11, 16'h1111, lat, rc, rp, wl, rv, dq, ub, lb, wt, ot, dt);
        bus_xfer(1'b1, 1'b0, 20'h00050, 2'b11, 16'h0000, lat, rc, rp, wl, rv, dq, ub, lb, wt, ot, dt);
        bus_xfer(1'b0, 1'b1, 20'h00051, 2'b11, 16'h2222, lat, rc, rp, wl, rv, dq, ub, lb, wt, ot, dt);
        bus_xfer(1'b1, 1'b0, 20'h00051, 2'b11, 16'h0000, lat, rc, rp, wl, rv, dq, ub, lb, wt, ot, dt);
        bus_xfer(1'b1, 1'b0, 20'h00050, 2'b11, 16'h0000, lat, rc, rp, wl, rv, dq, ub, lb, wt, ot, dt);
        n_tests++; if (rv !== 16'h1111) begin n_fail++; $display("FAIL stats_readback got %h exp 1111", rv); end
`ifdef SRAM_BRIDGE_STATS_EN
        exp_rd = 32'd3; exp_wr = 32'd2;
`else
        exp_rd = 32'd0; exp_wr = 32'd0;
`endif
        n_tests++; if (rd_count !== exp_rd) begin n_fail++; $display("FAIL stats_rd_count got %0d exp %0d", rd_count, exp_rd); end
        n_tests++; if (wr_count !== exp_wr) begin n_fail++; $display("FAIL stats_wr_count got %0d exp %0d", wr_count, exp_wr); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_read_write_conflict();
        test_byte_enable();
        test_drop_request();
        test_reset_mid_write();
        test_stats();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
